multicycle_controller: RTL and testbench

//  Multi-cycle successor to the single-cycle MIPS main decoder. It runs one instruction per

---
 rtl/multicycle_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB per opcode, handles
// memory ready handshakes with a bounded wait, and traps illegal opcodes and bus timeouts.
module multicycle_controller #(
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               instr_done,
    output logic [CNT_W-1:0]   retired,
    output logic               illegal_op,
    output logic               bus_error
);

    localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL,
        S_BUS_ERR
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [5:0]         r_opcode;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_retired;
    logic               w_wait_state;
    logic               w_wait_expired;
    logic               w_unused_instr;

    // Only the opcode field of the instruction word matters to the controller.
    assign w_unused_instr = ^instruction[INSTR_W-7:0];

    assign w_wait_state   = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_wait_expired = (TIMEOUT != 0) && (r_wait == TIMEOUT_C) && !mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_FETCH && mem_ready) begin
                r_opcode <= instruction[INSTR_W-1 -: 6];
            end
            // Any state change clears the counter; it is only consulted in the wait states.
            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if (w_wait_state && !mem_ready && (TIMEOUT != 0) && (r_wait != TIMEOUT_C)) begin
                r_wait <= r_wait + 1'b1;
            end
            if (instr_done) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready)           w_state_next = S_DECODE;
                else if (w_wait_expired) w_state_next = S_BUS_ERR;
            end
            S_DECODE: begin
                case (r_opcode)
                    OP_RTYPE:                 w_state_next = S_EXEC_R;
                    OP_LW, OP_SW:             w_state_next = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI: w_state_next = S_EXEC_I;
                    OP_BEQ:                   w_state_next = S_BRANCH;
                    OP_J:                     w_state_next = S_JUMP;
                    default:                  w_state_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   w_state_next = S_WB_R;
            S_WB_R:     w_state_next = S_FETCH;
            S_EXEC_I:   w_state_next = S_WB_I;
            S_WB_I:     w_state_next = S_FETCH;
            S_MEM_ADDR: w_state_next = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)           w_state_next = S_MEM_WB;
                else if (w_wait_expired) w_state_next = S_BUS_ERR;
            end
            S_MEM_WB:   w_state_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)           w_state_next = S_FETCH;
                else if (w_wait_expired) w_state_next = S_BUS_ERR;
            end
            S_BRANCH:   w_state_next = S_FETCH;
            S_JUMP:     w_state_next = S_FETCH;
            S_ILLEGAL:  w_state_next = S_ILLEGAL;
            S_BUS_ERR:  w_state_next = S_BUS_ERR;
            default:    w_state_next = S_FETCH;
        endcase
    end

    // Outputs are forced low for the whole reset cycle, whatever state was interrupted.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        bus_error     = 1'b0;
        if (!reset) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_WB_R: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (r_opcode == OP_ADDI) ? 2'b00 : 2'b11;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_ILLEGAL: illegal_op = 1'b1;
                S_BUS_ERR: bus_error  = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired = reset ? '0 : r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one step per clock, every control output and
// the retired count compared against hand-derived per-state values.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op, bus_error;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [31:0] retired;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret;
    logic [19:0] w_ctl;

    multicycle_controller #(.INSTR_W(32), .TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .retired(retired), .illegal_op(illegal_op),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // Field order: pw pwc psrc iord mrd mwr irw rdst m2r rw asa asb aop done ill berr
    assign w_ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                    instr_done, illegal_op, bus_error};

    localparam logic [19:0] E_RST   = 20'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_0_0;
    localparam logic [19:0] E_F_RDY = 20'b1_0_00_0_1_0_1_0_0_0_0_01_00_0_0_0;
    localparam logic [19:0] E_F_WT  = 20'b0_0_00_0_1_0_0_0_0_0_0_01_00_0_0_0;
    localparam logic [19:0] E_DEC   = 20'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_0_0;
    localparam logic [19:0] E_EX_R  = 20'b0_0_00_0_0_0_0_0_0_0_1_00_10_0_0_0;
    localparam logic [19:0] E_WB_R  = 20'b0_0_00_0_0_0_0_1_0_1_0_00_00_1_0_0;
    localparam logic [19:0] E_EX_IA = 20'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0_0;
    localparam logic [19:0] E_EX_IL = 20'b0_0_00_0_0_0_0_0_0_0_1_10_11_0_0_0;
    localparam logic [19:0] E_WB_I  = 20'b0_0_00_0_0_0_0_0_0_1_0_00_00_1_0_0;
    localparam logic [19:0] E_MADDR = 20'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0_0;
    localparam logic [19:0] E_MRD   = 20'b0_0_00_1_1_0_0_0_0_0_0_00_00_0_0_0;
    localparam logic [19:0] E_MWB   = 20'b0_0_00_0_0_0_0_0_1_1_0_00_00_1_0_0;
    localparam logic [19:0] E_MWR_W = 20'b0_0_00_1_0_1_0_0_0_0_0_00_00_0_0_0;
    localparam logic [19:0] E_MWR_D = 20'b0_0_00_1_0_1_0_0_0_0_0_00_00_1_0_0;
    localparam logic [19:0] E_BR    = 20'b0_1_01_0_0_0_0_0_0_0_1_00_01_1_0_0;
    localparam logic [19:0] E_JMP   = 20'b1_0_10_0_0_0_0_0_0_0_0_00_00_1_0_0;
    localparam logic [19:0] E_ILL   = 20'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_1_0;
    localparam logic [19:0] E_BERR  = 20'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_0_1;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

    // One clock cycle: drive inputs on the falling edge, check outputs 1 ns later.
    task automatic step(input logic rst, input logic rdy, input logic [5:0] op,
                        input string tag, input logic [19:0] exp_ctl);
        @(negedge clk);
        reset       = rst;
        mem_ready   = rdy;
        instruction = {op, 26'h2ABCDEF};
        #1;
        checks++;
        assert (w_ctl === exp_ctl)
            else begin errors++; $error("FAIL %s ctl got %b want %b", tag, w_ctl, exp_ctl); end
        checks++;
        assert (retired === exp_ret)
            else begin errors++; $error("FAIL %s retired got %0d want %0d", tag, retired, exp_ret); end
        $display("step %-10s rst=%b rdy=%b op=%b ctl=%b retired=%0d", tag, rst, rdy, op, w_ctl, retired);
    endtask

    initial begin
        exp_ret = 0;
        step(1, 0, OP_R, "reset0", E_RST);
        step(1, 1, OP_R, "reset1", E_RST);

        // add, zero wait
        step(0, 1, OP_R, "add_f", E_F_RDY);
        step(0, 1, OP_R, "add_d", E_DEC);
        step(0, 1, OP_R, "add_ex", E_EX_R);
        step(0, 1, OP_R, "add_wb", E_WB_R);
        exp_ret = 1;

        // addi with two fetch wait cycles (no IR/PC load until ready)
        step(0, 0, OP_ADDI, "addi_fw0", E_F_WT);
        step(0, 0, OP_ADDI, "addi_fw1", E_F_WT);
        step(0, 1, OP_ADDI, "addi_f", E_F_RDY);
        step(0, 1, OP_ADDI, "addi_d", E_DEC);
        step(0, 1, OP_ADDI, "addi_ex", E_EX_IA);
        step(0, 1, OP_ADDI, "addi_wb", E_WB_I);
        exp_ret = 2;

        // andi / ori; bus contents and ready are ignored after FETCH
        step(0, 1, OP_ANDI, "andi_f", E_F_RDY);
        step(0, 0, OP_BAD, "andi_d", E_DEC);
        step(0, 0, OP_BAD, "andi_ex", E_EX_IL);
        step(0, 1, OP_BAD, "andi_wb", E_WB_I);
        exp_ret = 3;
        step(0, 1, OP_ORI, "ori_f", E_F_RDY);
        step(0, 1, OP_ORI, "ori_d", E_DEC);
        step(0, 1, OP_ORI, "ori_ex", E_EX_IL);
        step(0, 1, OP_ORI, "ori_wb", E_WB_I);
        exp_ret = 4;

        // lw with 3 wait cycles in MEM_RD: 8 cycles total
        step(0, 1, OP_LW, "lw_f", E_F_RDY);
        step(0, 1, OP_LW, "lw_d", E_DEC);
        step(0, 1, OP_LW, "lw_addr", E_MADDR);
        for (int i = 0; i < 3; i++) step(0, 0, OP_LW, "lw_rdw", E_MRD);
        step(0, 1, OP_LW, "lw_rd", E_MRD);
        step(0, 0, OP_LW, "lw_wb", E_MWB);
        exp_ret = 5;

        // sw, zero wait
        step(0, 1, OP_SW, "sw_f", E_F_RDY);
        step(0, 1, OP_SW, "sw_d", E_DEC);
        step(0, 1, OP_SW, "sw_addr", E_MADDR);
        step(0, 1, OP_SW, "sw_wr", E_MWR_D);
        exp_ret = 6;

        // reset clears retired; beq then j
        exp_ret = 0;
        step(1, 1, OP_BEQ, "rst_a", E_RST);
        step(0, 1, OP_BEQ, "beq_f", E_F_RDY);
        step(0, 1, OP_BEQ, "beq_d", E_DEC);
        step(0, 1, OP_BEQ, "beq_br", E_BR);
        exp_ret = 1;
        step(0, 1, OP_J, "j_f", E_F_RDY);
        step(0, 1, OP_J, "j_d", E_DEC);
        step(0, 1, OP_J, "j_jmp", E_JMP);
        exp_ret = 2;

        // illegal opcode is terminal until reset
        step(0, 1, OP_BAD, "ill_f", E_F_RDY);
        step(0, 1, OP_R, "ill_d", E_DEC);
        for (int i = 0; i < 20; i++) step(0, logic'(i[0]), OP_R, "ill_hold", E_ILL);
        exp_ret = 0;
        step(1, 1, OP_R, "rst_b", E_RST);

        // sw with ready never arriving: wait count reaches 15 then traps
        step(0, 1, OP_SW, "swto_f", E_F_RDY);
        step(0, 1, OP_SW, "swto_d", E_DEC);
        step(0, 1, OP_SW, "swto_addr", E_MADDR);
        for (int i = 0; i < 16; i++) step(0, 0, OP_SW, "swto_wait", E_MWR_W);
        for (int i = 0; i < 5; i++) step(0, (i == 2), OP_SW, "swto_berr", E_BERR);
        step(1, 0, OP_SW, "rst_c", E_RST);

        // ready arriving in the very cycle the count hits 15 completes normally
        step(0, 1, OP_SW, "swok_f", E_F_RDY);
        step(0, 1, OP_SW, "swok_d", E_DEC);
        step(0, 1, OP_SW, "swok_addr", E_MADDR);
        for (int i = 0; i < 15; i++) step(0, 0, OP_SW, "swok_wait", E_MWR_W);
        step(0, 1, OP_SW, "swok_wr", E_MWR_D);
        exp_ret = 1;

        // reset during MEM_WR wait aborts with no write strobe
        step(0, 1, OP_SW, "swab_f", E_F_RDY);
        step(0, 1, OP_SW, "swab_d", E_DEC);
        step(0, 1, OP_SW, "swab_addr", E_MADDR);
        for (int i = 0; i < 3; i++) step(0, 0, OP_SW, "swab_wait", E_MWR_W);
        exp_ret = 0;
        step(1, 1, OP_SW, "rst_d", E_RST);

        // fetch timeout also traps
        for (int i = 0; i < 16; i++) step(0, 0, OP_R, "fto_wait", E_F_WT);
        step(0, 1, OP_R, "fto_berr", E_BERR);
        step(0, 0, OP_R, "fto_berr2", E_BERR);
        step(1, 0, OP_R, "rst_e", E_RST);
        step(0, 1, OP_R, "final_f", E_F_RDY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
